mb_header_dec: RTL and testbench

- CAVLC intra macroblock-header parser, the decode-side counterpart of the MB header encoder in h264_core.
- Consumes an MSB-first bit window from an upstream bitstream buffer and extracts mb_type, intra4x4 prev/rem modes, intra16x16 mode, chroma pred mode, cbp (me(v) intra mapping) and mb_qp_delta.
- Reconstructs QP and hands one header record per macroblock to the residual CAVLC decoder.

---
 rtl/h264_dec_defs.sv | 41 ++++
 rtl/exp_golomb_dec.sv | 46 ++++
 rtl/mb_header_dec.sv | 186 ++++++++++++++++++
 tb/tb_mb_header_dec.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/h264_dec_defs.sv
// Shared definitions for the intra macroblock-header decoder: FSM states, element limits,
// header record layout and the intra cbp me(v) inverse mapping.
package h264_dec_defs;

  typedef enum logic [2:0] {
    S_IDLE, S_MBTYPE, S_PRED4, S_CHROMA, S_CBP, S_DQP, S_DONE, S_ERR
  } state_t;

  localparam int QP_MAX_DEF = 51;

  localparam logic [5:0] MBT_I4X4      = 6'd0;
  localparam logic [5:0] MBT_I16_LAST  = 6'd24;
  localparam logic [5:0] CHROMA_MAX    = 6'd3;
  localparam logic [5:0] CBP_CODE_MAX  = 6'd47;
  localparam logic signed [6:0] DQP_HI = 7'sd25;
  localparam logic signed [6:0] DQP_LO = -7'sd26;

  typedef struct packed {
    logic        mb_type_intra;
    logic [1:0]  mode16;
    logic [15:0] flags;
    logic [47:0] rem;
    logic [1:0]  chroma;
    logic [5:0]  cbp;
    logic [5:0]  qp;
  } hdr_rec_t;

  localparam logic [5:0] CBP_INTRA_TAB [0:47] = '{
    6'd47, 6'd31, 6'd15, 6'd0,  6'd23, 6'd27, 6'd29, 6'd30,
    6'd7,  6'd11, 6'd13, 6'd14, 6'd39, 6'd43, 6'd45, 6'd46,
    6'd16, 6'd3,  6'd5,  6'd10, 6'd12, 6'd19, 6'd21, 6'd26,
    6'd28, 6'd35, 6'd37, 6'd42, 6'd44, 6'd1,  6'd2,  6'd4,
    6'd8,  6'd17, 6'd18, 6'd20, 6'd24, 6'd6,  6'd9,  6'd22,
    6'd25, 6'd32, 6'd33, 6'd34, 6'd36, 6'd40, 6'd38, 6'd41
  };

  function automatic logic [5:0] cbp_intra_inv(input logic [5:0] code);
    return (code <= CBP_CODE_MAX) ? CBP_INTRA_TAB[code] : 6'd0;
  endfunction

endpackage

// File: rtl/exp_golomb_dec.sv
// Combinational Exp-Golomb decoder on the head of an MSB-first bit window.
// Prefixes longer than five zeros are flagged as err (no legal header element needs them).
module exp_golomb_dec #(
  parameter int WIN_W = 16
) (
  input  logic [WIN_W-1:0] win,
  output logic [5:0]       code_num,
  output logic [6:0]       se_val,
  output logic [4:0]       len,
  output logic             err
);

  logic [10:0] top11, mask, tail;
  logic [2:0]  lz;
  logic        found;
  logic [3:0]  rs;

  assign top11 = win[WIN_W-1 -: 11];

  always_comb begin
    lz    = 3'd6;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!found && top11[10-i]) begin
        lz    = 3'(i);
        found = 1'b1;
      end
    end
    // info bits sit right after the marker bit; shift them to the bottom and mask
    rs       = 4'd10 - {lz, 1'b0};
    mask     = (11'd1 << lz) - 11'd1;
    tail     = (top11 >> rs) & mask;
    err      = !found;
    code_num = found ? 6'(mask + tail) : 6'd0;
    len      = found ? {1'b0, lz, 1'b1} : 5'd0;
  end

  assign se_val = code_num[0] ? (({1'b0, code_num} + 7'd1) >> 1)
                              : (7'd0 - ({1'b0, code_num} >> 1));

  if (WIN_W > 11) begin : g_low
    logic unused_low;
    assign unused_low = ^win[WIN_W-12:0];
  end

endmodule

// File: rtl/mb_header_dec.sv
// CAVLC intra macroblock-header parser: walks mb_type, intra modes, chroma mode, cbp and
// mb_qp_delta off the bit window and publishes one header record per macroblock.
//   state  | meaning
//   IDLE   | waiting for start
//   MBTYPE | decode mb_type ue(v)
//   PRED4  | 16 x intra4x4 prev flag / rem mode
//   CHROMA | decode intra_chroma_pred_mode ue(v)
//   CBP    | decode coded_block_pattern me(v)
//   DQP    | decode mb_qp_delta se(v)
//   DONE   | publish record, hdr_valid pulse
//   ERR    | illegal code, hdr_err pulse
module mb_header_dec
  import h264_dec_defs::*;
#(
  parameter int WIN_W  = 16,
  parameter int QP_MAX = QP_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             first_mb,
  input  logic [5:0]       slice_qp,
  input  logic             bs_valid,
  input  logic [WIN_W-1:0] bs_window,
  output logic             bs_consume,
  output logic [4:0]       bs_len,
  output logic             busy,
  output logic             hdr_valid,
  output logic             hdr_err,
  output logic             mb_type_intra,
  output logic [1:0]       intra16x16_mode,
  output logic [15:0]      intra4x4_flag,
  output logic [47:0]      intra4x4_rem,
  output logic [1:0]       chroma_mode,
  output logic [5:0]       cbp,
  output logic [5:0]       qp
);

  localparam logic [7:0] QP_MOD  = 8'(QP_MAX + 1);
  localparam logic [7:0] QP_MOD2 = 8'(2 * (QP_MAX + 1));

  state_t   state, state_d;
  hdr_rec_t pend, rec_q, rec_next;
  logic     first_lat;
  logic [3:0] blk_cnt;
  logic [5:0] qp_prev, base, qp_new, cbp_lut;
  logic [5:0] code_num;
  logic [6:0] se_val;
  logic [4:0] eg_len;
  logic       eg_err, dqp_bad;
  logic [4:0] c16;
  logic [2:0] grp16;
  logic [1:0] chroma16;
  logic [7:0] qp_sum, qp_wrap;

  exp_golomb_dec #(.WIN_W(WIN_W)) u_eg (
    .win      (bs_window),
    .code_num (code_num),
    .se_val   (se_val),
    .len      (eg_len),
    .err      (eg_err)
  );

  // I_16x16 mb_type packs mode, chroma cbp and luma cbp into codeNum-1
  assign c16      = 5'(code_num - 6'd1);
  assign grp16    = c16[4:2];
  assign chroma16 = (grp16 >= 3'd3) ? 2'(grp16 - 3'd3) : grp16[1:0];
  assign cbp_lut  = cbp_intra_inv(code_num);
  assign dqp_bad  = ($signed(se_val) > DQP_HI) || ($signed(se_val) < DQP_LO);

  assign base    = first_lat ? slice_qp : qp_prev;
  assign qp_sum  = {2'b00, base} + {se_val[6], se_val} + QP_MOD;
  assign qp_wrap = (qp_sum >= QP_MOD2) ? qp_sum - QP_MOD2 :
                   (qp_sum >= QP_MOD)  ? qp_sum - QP_MOD  : qp_sum;
  assign qp_new  = (state == S_DQP) ? 6'(qp_wrap) : base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    bs_consume   = 1'b0;
    bs_len       = 5'd0;
    rec_next     = pend;
    rec_next.cbp = (state == S_CBP) ? cbp_lut : pend.cbp;
    rec_next.qp  = qp_new;
    unique case (state)
      S_IDLE:   if (start) state_d = S_MBTYPE;
      S_MBTYPE: if (bs_valid) begin
        if (eg_err || code_num > MBT_I16_LAST) state_d = S_ERR;
        else begin
          bs_consume = 1'b1;
          bs_len     = eg_len;
          state_d    = (code_num == MBT_I4X4) ? S_PRED4 : S_CHROMA;
        end
      end
      S_PRED4:  if (bs_valid) begin
        bs_consume = 1'b1;
        bs_len     = bs_window[WIN_W-1] ? 5'd1 : 5'd4;
        if (blk_cnt == 4'd0) state_d = S_CHROMA;
      end
      S_CHROMA: if (bs_valid) begin
        if (eg_err || code_num > CHROMA_MAX) state_d = S_ERR;
        else begin
          bs_consume = 1'b1;
          bs_len     = eg_len;
          state_d    = pend.mb_type_intra ? S_DQP : S_CBP;
        end
      end
      S_CBP:    if (bs_valid) begin
        if (eg_err || code_num > CBP_CODE_MAX) state_d = S_ERR;
        else begin
          bs_consume = 1'b1;
          bs_len     = eg_len;
          state_d    = (cbp_lut == 6'd0) ? S_DONE : S_DQP;
        end
      end
      S_DQP:    if (bs_valid) begin
        if (eg_err || dqp_bad) state_d = S_ERR;
        else begin
          bs_consume = 1'b1;
          bs_len     = eg_len;
          state_d    = S_DONE;
        end
      end
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_lat <= 1'b0;
      pend      <= '0;
      rec_q     <= '0;
      blk_cnt   <= 4'd0;
      qp_prev   <= 6'd0;
    end else begin
      if (state == S_IDLE && start) begin
        first_lat <= first_mb;
        pend      <= '0;
      end
      if (bs_consume) begin
        unique case (state)
          S_MBTYPE: begin
            pend.mb_type_intra <= (code_num != MBT_I4X4);
            blk_cnt            <= 4'd15;
            if (code_num != MBT_I4X4) begin
              pend.mode16 <= c16[1:0];
              pend.cbp    <= {chroma16, (c16 >= 5'd12) ? 4'hF : 4'h0};
            end
          end
          S_PRED4: begin
            // shift in so block 0 lands in the MSBs after 16 blocks
            pend.flags <= {pend.flags[14:0], bs_window[WIN_W-1]};
            pend.rem   <= {pend.rem[44:0],
                           bs_window[WIN_W-1] ? 3'd0 : bs_window[WIN_W-2 -: 3]};
            blk_cnt    <= blk_cnt - 4'd1;
          end
          S_CHROMA: pend.chroma <= code_num[1:0];
          S_CBP:    pend.cbp    <= cbp_lut;
          default:  ;
        endcase
      end
      if (state_d == S_DONE) begin
        rec_q   <= rec_next;
        qp_prev <= rec_next.qp;
      end
    end
  end

  assign busy            = (state != S_IDLE);
  assign hdr_valid       = (state == S_DONE);
  assign hdr_err         = (state == S_ERR);
  assign mb_type_intra   = rec_q.mb_type_intra;
  assign intra16x16_mode = rec_q.mode16;
  assign intra4x4_flag   = rec_q.flags;
  assign intra4x4_rem    = rec_q.rem;
  assign chroma_mode     = rec_q.chroma;
  assign cbp             = rec_q.cbp;
  assign qp              = rec_q.qp;

endmodule

// File: tb/tb_mb_header_dec.sv
// Directed bench for mb_header_dec: a bit-queue feeder models the upstream buffer and
// each header is checked against hand-derived record fields, consume lengths and latency.
module tb_mb_header_dec;

  localparam int WIN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, first_mb, bs_valid;
  logic [5:0]       slice_qp;
  logic [WIN_W-1:0] bs_window;
  logic             bs_consume, busy, hdr_valid, hdr_err, mb_type_intra;
  logic [4:0]       bs_len;
  logic [1:0]       intra16x16_mode, chroma_mode;
  logic [15:0]      intra4x4_flag;
  logic [47:0]      intra4x4_rem;
  logic [5:0]       cbp, qp;

  int compared = 0;
  int mismatched = 0;
  bit q[$];
  int len_log[$];
  bit tog = 1'b0, phase = 1'b0, pend_cons = 1'b0;
  int pend_len = 0, bad_cons = 0, valid_cnt = 0;
  int steps, vsnap, lsum;
  bit got_v, got_e;

  mb_header_dec #(.WIN_W(WIN_W), .QP_MAX(51)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_mb(first_mb), .slice_qp(slice_qp),
    .bs_valid(bs_valid), .bs_window(bs_window), .bs_consume(bs_consume), .bs_len(bs_len),
    .busy(busy), .hdr_valid(hdr_valid), .hdr_err(hdr_err), .mb_type_intra(mb_type_intra),
    .intra16x16_mode(intra16x16_mode), .intra4x4_flag(intra4x4_flag),
    .intra4x4_rem(intra4x4_rem), .chroma_mode(chroma_mode), .cbp(cbp), .qp(qp)
  );

  always #5 clk = ~clk;

  // Feeder: pops last cycle's consume at negedge, drives the window, samples just before posedge
  always begin
    logic [WIN_W-1:0] win;
    @(negedge clk);
    if (pend_cons) begin
      for (int i = 0; i < pend_len; i++) if (q.size() > 0) void'(q.pop_front());
      len_log.push_back(pend_len);
    end
    win = '0;
    for (int i = 0; i < WIN_W; i++) if (i < q.size()) win[WIN_W-1-i] = q[i];
    phase     = ~phase;
    bs_window = win;
    bs_valid  = (q.size() >= WIN_W) && (!tog || phase);
    #4;
    pend_cons = bs_consume;
    pend_len  = int'(bs_len);
    if (bs_consume && !bs_valid) bad_cons++;
    if (hdr_valid) valid_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic load(input string s);
    q.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "1") q.push_back(1'b1);
      else if (s[i] == "0") q.push_back(1'b0);
    end
    repeat (16) q.push_back(1'b1);
  endtask

  task automatic run(input bit first, input logic [5:0] sqp);
    step();
    len_log.delete();
    start = 1'b1; first_mb = first; slice_qp = sqp;
    steps = 0; got_v = 1'b0; got_e = 1'b0;
    for (int i = 1; i <= 80 && !got_v && !got_e; i++) begin
      step();
      start = 1'b0;
      steps = i;
      got_v = hdr_valid;
      got_e = hdr_err;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; first_mb = 1'b0; slice_qp = 6'd0;
    bs_valid = 1'b0; bs_window = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", hdr_valid, 0);
    chk("rst_err", hdr_err, 0);
    chk("rst_consume", bs_consume, 0);
    chk("rst_qp", qp, 0);
    chk("rst_cbp", cbp, 0);
    chk("rst_flags", intra4x4_flag, 0);

    // I16x16 codeNum 7: mode 2, chroma cbp 1, luma 0; chroma 0; dqp 0
    load("0001000 1 1");
    run(1'b1, 6'd28);
    chk("t1_valid", got_v, 1);
    chk("t1_steps", steps, 4);
    chk("t1_ncons", len_log.size(), 3);
    chk("t1_len0", len_log[0], 7);
    chk("t1_len1", len_log[1], 1);
    chk("t1_len2", len_log[2], 1);
    chk("t1_type", mb_type_intra, 1);
    chk("t1_mode", intra16x16_mode, 2);
    chk("t1_cbp", cbp, 6'b010000);
    chk("t1_qp", qp, 28);

    // I4x4 all prev flags, chroma 0, cbp codeNum 3 -> 0, no dqp
    load("1 1111111111111111 1 00100");
    run(1'b0, 6'd10);
    chk("t2_valid", got_v, 1);
    chk("t2_steps", steps, 20);
    chk("t2_ncons", len_log.size(), 19);
    lsum = 0;
    foreach (len_log[i]) lsum += len_log[i];
    chk("t2_lensum", lsum, 23);
    chk("t2_lenlast", len_log[18], 5);
    chk("t2_type", mb_type_intra, 0);
    chk("t2_flags", intra4x4_flag, 16'hFFFF);
    chk("t2_rem", intra4x4_rem, 48'h0);
    chk("t2_cbp", cbp, 0);
    chk("t2_qp", qp, 28);

    // I4x4 block0 rem 5, cbp codeNum 0 -> 47, dqp -1 from base 0 -> 51
    load("1 0101 111111111111111 1 1 011");
    run(1'b1, 6'd0);
    chk("t3_valid", got_v, 1);
    chk("t3_steps", steps, 21);
    chk("t3_flags", intra4x4_flag, 16'h7FFF);
    chk("t3_rem0", intra4x4_rem[47:45], 5);
    chk("t3_rem", intra4x4_rem, 48'hA000_0000_0000);
    chk("t3_cbp", cbp, 47);
    chk("t3_qp", qp, 51);

    // Same I16x16 header as t1 with bs_valid toggling
    tog = 1'b1;
    load("0001000 1 1");
    run(1'b1, 6'd28);
    tog = 1'b0;
    chk("t4_valid", got_v, 1);
    chk("t4_ncons", len_log.size(), 3);
    chk("t4_len0", len_log[0], 7);
    chk("t4_badcons", bad_cons, 0);
    chk("t4_mode", intra16x16_mode, 2);
    chk("t4_cbp", cbp, 6'b010000);
    chk("t4_qp", qp, 28);

    // I16x16 codeNum 24: mode 3, cbp 47; chroma 2; dqp +25 from 28 wraps to 1
    load("000011001 011 00000110010");
    run(1'b0, 6'd0);
    chk("t5_valid", got_v, 1);
    chk("t5_mode", intra16x16_mode, 3);
    chk("t5_chroma", chroma_mode, 2);
    chk("t5_cbp", cbp, 47);
    chk("t5_qp", qp, 1);

    // mb_type with six leading zeros
    load("0000001");
    run(1'b0, 6'd0);
    chk("t6_err", got_e, 1);
    chk("t6_valid", got_v, 0);
    chk("t6_ncons", len_log.size(), 0);
    chk("t6_qp_hold", qp, 1);
    chk("t6_cbp_hold", cbp, 47);

    // chroma codeNum 4
    load("010 00101");
    run(1'b0, 6'd0);
    chk("t7_err", got_e, 1);
    chk("t7_ncons", len_log.size(), 1);
    chk("t7_mode_hold", intra16x16_mode, 3);

    // dqp +26 out of range
    load("010 1 00000110100");
    run(1'b0, 6'd0);
    chk("t8_err", got_e, 1);
    chk("t8_ncons", len_log.size(), 2);
    chk("t8_qp_hold", qp, 1);

    // reset during PRED4 block 7
    load("1 1111111111111111 1 00100");
    step();
    len_log.delete();
    start = 1'b1; first_mb = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      start = 1'b0;
    end
    chk("t9_ncons_pre", len_log.size(), 8);
    vsnap = valid_cnt;
    rst_n = 1'b0;
    step();
    chk("t9_busy", busy, 0);
    chk("t9_qp_rst", qp, 0);
    rst_n = 1'b1;
    repeat (25) step();
    chk("t9_novalid", valid_cnt, vsnap);
    load("0001000 1 1");
    run(1'b1, 6'd30);
    chk("t9_valid", got_v, 1);
    chk("t9_cbp", cbp, 6'b010000);
    chk("t9_qp", qp, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
